// File: rtl/rv_pkg.sv
// Shared register-file definitions used by the writeback path and its bench.
package rv_pkg;
    localparam int REG_ADDR_W = 5;
    localparam int XLEN       = 32;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       data;
    } wb_entry_t;
endpackage

// File: rtl/rf_writeback_queue_bypass.sv
// Combinational youngest-match search over queued writes plus the committing write.
module rf_bypass_match
    import rv_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic [REG_ADDR_W-1:0] sel,
    input  logic [REG_ADDR_W-1:0] ent_rd   [DEPTH],
    input  logic [WIDTH-1:0]      ent_data [DEPTH],
    input  logic [DEPTH-1:0]      ent_valid,
    input  logic                  out_valid,
    input  logic [REG_ADDR_W-1:0] out_rd,
    input  logic [WIDTH-1:0]      out_data,
    output logic                  hit,
    output logic [WIDTH-1:0]      val
);

    // Entries arrive ordered oldest to youngest; later matches override earlier ones.
    always_comb begin
        hit = 1'b0;
        val = '0;
        if (out_valid && out_rd == sel) begin
            hit = 1'b1;
            val = out_data;
        end
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (ent_valid[i] && ent_rd[i] == sel) begin
                hit = 1'b1;
                val = ent_data[i];
            end
        end
        if (sel == '0) begin
            hit = 1'b0;
            val = '0;
        end
    end

endmodule

// File: rtl/rf_writeback_queue.sv
// Arbitrates ALU/LSU results into an in-order FIFO that drains one regfile write per cycle.
module rf_writeback_queue
    import rv_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       alu_valid,
    output logic                       alu_ready,
    input  logic [4:0]                 alu_rd,
    input  logic [WIDTH-1:0]           alu_data,
    input  logic                       lsu_valid,
    output logic                       lsu_ready,
    input  logic [4:0]                 lsu_rd,
    input  logic [WIDTH-1:0]           lsu_data,
    output logic                       rf_w_enable,
    output logic [4:0]                 rf_rd_select,
    output logic [WIDTH-1:0]           rf_w_val,
    input  logic [4:0]                 byp_rs1_select,
    input  logic [4:0]                 byp_rs2_select,
    output logic                       byp_rs1_hit,
    output logic [WIDTH-1:0]           byp_rs1_val,
    output logic                       byp_rs2_hit,
    output logic [WIDTH-1:0]           byp_rs2_val,
    output logic [$clog2(DEPTH):0]     pending_cnt,
    output logic                       empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic {FAV_ALU, FAV_LSU} rr_e;

    rr_e                   rr;
    logic [REG_ADDR_W-1:0] q_rd   [DEPTH];
    logic [WIDTH-1:0]      q_data [DEPTH];
    logic [PW-1:0]         wr_ptr, rd_ptr;
    logic [CW-1:0]         count;

    logic                  full, alu_fire, lsu_fire, push, pop;
    logic [REG_ADDR_W-1:0] push_rd;
    logic [WIDTH-1:0]      push_data;

    assign full = (count == CW'(DEPTH));
    assign pop  = (count != '0);

    always_comb begin
        alu_ready = 1'b0;
        lsu_ready = 1'b0;
        if (!full) begin
            if (alu_valid && lsu_valid) begin
                alu_ready = (rr == FAV_ALU);
                lsu_ready = (rr == FAV_LSU);
            end else if (lsu_valid) begin
                lsu_ready = 1'b1;
            end else begin
                alu_ready = 1'b1;
            end
        end
    end

    assign alu_fire  = alu_valid && alu_ready;
    assign lsu_fire  = lsu_valid && lsu_ready;
    assign push_rd   = alu_fire ? alu_rd : lsu_rd;
    assign push_data = alu_fire ? alu_data : lsu_data;
    // Writes to x0 complete the handshake but never occupy a slot.
    assign push      = (alu_fire || lsu_fire) && (push_rd != '0);

    always_ff @(posedge clk) begin
        if (push) begin
            q_rd[wr_ptr]   <= push_rd;
            q_data[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr           <= FAV_ALU;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            rf_w_enable  <= 1'b0;
            rf_rd_select <= '0;
            rf_w_val     <= '0;
        end else begin
            if (alu_fire)      rr <= FAV_LSU;
            else if (lsu_fire) rr <= FAV_ALU;
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop) begin
                rd_ptr       <= rd_ptr + PW'(1);
                rf_w_enable  <= 1'b1;
                rf_rd_select <= q_rd[rd_ptr];
                rf_w_val     <= q_data[rd_ptr];
            end else begin
                rf_w_enable  <= 1'b0;
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    assign pending_cnt = count;
    assign empty       = (count == '0) && !rf_w_enable;

    logic [REG_ADDR_W-1:0] ord_rd    [DEPTH];
    logic [WIDTH-1:0]      ord_data  [DEPTH];
    logic [DEPTH-1:0]      ord_valid;

    // Rotate storage so the search sees entries oldest-first regardless of pointer wrap.
    always_comb begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
            ord_rd[i]    = q_rd[rd_ptr + PW'(i)];
            ord_data[i]  = q_data[rd_ptr + PW'(i)];
            ord_valid[i] = (CW'(i) < count);
        end
    end

    rf_bypass_match #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_byp_rs1 (
        .sel       (byp_rs1_select),
        .ent_rd    (ord_rd),
        .ent_data  (ord_data),
        .ent_valid (ord_valid),
        .out_valid (rf_w_enable),
        .out_rd    (rf_rd_select),
        .out_data  (rf_w_val),
        .hit       (byp_rs1_hit),
        .val       (byp_rs1_val)
    );

    rf_bypass_match #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_byp_rs2 (
        .sel       (byp_rs2_select),
        .ent_rd    (ord_rd),
        .ent_data  (ord_data),
        .ent_valid (ord_valid),
        .out_valid (rf_w_enable),
        .out_rd    (rf_rd_select),
        .out_data  (rf_w_val),
        .hit       (byp_rs2_hit),
        .val       (byp_rs2_val)
    );

endmodule
